ahb_sram_slave: RTL

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave_pkg.sv | 60 ++++++
 rtl/ahb_sram_slave_array.sv | 30 +++
 rtl/ahb_sram_slave.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB types for the SRAM slave: transfer/size encodings, response
// codes, slave FSM states, the master/slave bundles and a byte-lane helper.
package AHB_package;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        HSIZE_BYTE     = 3'b000,
        HSIZE_HALFWORD = 3'b001,
        HSIZE_WORD     = 3'b010,
        HSIZE_DWORD    = 3'b011,
        HSIZE_4WORD    = 3'b100,
        HSIZE_8WORD    = 3'b101,
        HSIZE_16WORD   = 3'b110,
        HSIZE_32WORD   = 3'b111
    } hsize_type;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SLV_IDLE = 2'b00,
        SLV_WAIT = 2'b01,
        SLV_ERR1 = 2'b10,
        SLV_ERR2 = 2'b11
    } slv_state_type;

    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        hsize_type   hsize;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
        htrans_type  htrans;
        logic        hmastlock;
        logic [31:0] hwdata;
    } mas_send_type;

    typedef struct packed {
        logic        hreadyout;
        logic        hresp;
        logic [31:0] hrdata;
    } slv_send_type;

    // Little-endian lane enables for a transfer of the given size (0..2).
    function automatic logic [3:0] byte_enables(input logic [1:0] addr_lo,
                                                input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001 << addr_lo;
            2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_slave_array.sv
// Word-organised storage: byte-lane synchronous write, combinational read.
// Contents are deliberately not reset.
module ahb_sram_array #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [MEM_WORDS];

    // Commit enabled byte lanes on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and a two-cycle error
// response. Handshake: an address phase is taken when hsel, hready and an
// active htrans (NONSEQ/SEQ) coincide at a rising edge; the data phase ends
// in the first following cycle where this slave drives hreadyout=1, and only
// that cycle commits a write or presents read data.
module ahb_sram_slave
    import AHB_package::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic         hclk,
    input  logic         hreset,
    input  logic         hsel,
    input  logic         hready,
    input  mas_send_type mas_in,
    output slv_send_type slv_out
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_type state_q, state_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          valid_q, valid_d;
    logic [3:0]    cnt_q, cnt_d;

    logic          accept;
    logic          addr_err;
    logic          complete;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign unused_ok = ^{mas_in.hburst, mas_in.hprot, mas_in.hmastlock};

    assign accept = hsel && hready &&
                    ((mas_in.htrans == HTRANS_NONSEQ) || (mas_in.htrans == HTRANS_SEQ));

    assign addr_err = (mas_in.haddr >= MEM_BYTES) ||
                      (mas_in.hsize > HSIZE_WORD) ||
                      ((mas_in.hsize == HSIZE_HALFWORD) && mas_in.haddr[0]) ||
                      ((mas_in.hsize == HSIZE_WORD) && (mas_in.haddr[1:0] != 2'b00));

    // A data phase finishes in IDLE; WAIT always hands over to IDLE for it.
    assign complete = (state_q == SLV_IDLE) && valid_q;

    // Next-state: take new address phases in IDLE/ERR2, count waits, step errors.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            SLV_IDLE, SLV_ERR2: begin
                state_d = SLV_IDLE;
                valid_d = 1'b0;
                cnt_d   = 4'd0;
                if (accept) begin
                    addr_d  = mas_in.haddr[AW+1:0];
                    write_d = mas_in.hwrite;
                    size_d  = 2'(mas_in.hsize);
                    if (addr_err) begin
                        state_d = SLV_ERR1;
                    end else begin
                        valid_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = SLV_WAIT;
                        end
                    end
                end
            end
            SLV_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = SLV_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            SLV_ERR1: state_d = SLV_ERR2;
            default:  state_d = SLV_IDLE;
        endcase
    end

    // State register; reset drops any pending transfer.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= SLV_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data follows a same-word write in the next cycle automatically:
    // the write lands at the edge that takes the read's address phase.
    ahb_sram_array #(
        .MEM_WORDS(MEM_WORDS),
        .AW       (AW)
    ) u_array (
        .clk  (hclk),
        .we   (complete && write_q && !hreset),
        .be   (byte_enables(addr_q[1:0], size_q)),
        .addr (addr_q[AW+1:2]),
        .wdata(mas_in.hwdata),
        .rdata(rdata)
    );

    // Response outputs decoded from the current state.
    always_comb begin
        slv_out.hreadyout = 1'b1;
        slv_out.hresp     = HRESP_OKAY;
        slv_out.hrdata    = 32'h0;
        case (state_q)
            SLV_WAIT: slv_out.hreadyout = 1'b0;
            SLV_ERR1: begin
                slv_out.hreadyout = 1'b0;
                slv_out.hresp     = HRESP_ERROR;
            end
            SLV_ERR2: slv_out.hresp = HRESP_ERROR;
            default: ;
        endcase
        if (complete && !write_q) begin
            slv_out.hrdata = rdata;
        end
    end

endmodule
